mem_stage: RTL and testbench

//  EX/MEM pipeline register, data memory and MEM/WB pipeline register for the 5-stage MIPS core.

---
 rtl/mips_pkg.sv | 34 +++
 rtl/data_mem.sv | 25 ++
 rtl/mem_stage.sv | 161 ++++++++++++++++
 tb/tb_mem_stage.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared types for the MIPS MEM stage: control bundles carried through EX/MEM and MEM/WB.
// Packed-struct member order fixes the bit position of each control field.
package mips_pkg;

    localparam int unsigned MIPS_DATA_W     = 8;
    localparam int unsigned MIPS_PC_W       = 6;
    localparam int unsigned MIPS_REG_DIR_W  = 3;
    localparam int unsigned MIPS_MEM_ADDR_W = 5;

    typedef struct packed {
        logic mem_read;
        logic mem_write;
        logic mem_to_reg;
        logic reg_write;
        logic branch;
    } ex_mem_ctrl_t;

    typedef struct packed {
        logic mem_to_reg;
        logic reg_write;
    } mem_wb_ctrl_t;

    localparam ex_mem_ctrl_t EXM_BUBBLE = '0;
    localparam mem_wb_ctrl_t MWB_BUBBLE = '0;

    // Control bits that survive into write-back.
    function automatic mem_wb_ctrl_t wb_ctrl(input ex_mem_ctrl_t c);
        mem_wb_ctrl_t w;
        w.mem_to_reg = c.mem_to_reg;
        w.reg_write  = c.reg_write;
        return w;
    endfunction

endpackage

// File: rtl/data_mem.sv
// Data memory: 2**ADDR_WIDTH words, combinational read, synchronous write, contents not reset.
module data_mem #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
    end

    assign rdata = mem_q[addr];

endmodule

// File: rtl/mem_stage.sv
// MIPS MEM stage: EX/MEM register, data memory, branch resolve, MEM/WB register.
// Optional address range check enabled by defining MEM_ADDR_CHECK_EN.
module mem_stage
    import mips_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = MIPS_DATA_W,
    parameter int unsigned PC_WIDTH       = MIPS_PC_W,
    parameter int unsigned REG_DIR_WIDTH  = MIPS_REG_DIR_W,
    parameter int unsigned MEM_ADDR_WIDTH = MIPS_MEM_ADDR_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     stall,
    input  logic                     flush,
    input  logic [DATA_WIDTH-1:0]    ALUResult,
    input  logic [DATA_WIDTH-1:0]    data2,
    input  logic                     Zero,
    input  logic [REG_DIR_WIDTH-1:0] WriteReg,
    input  logic [PC_WIDTH-1:0]      ALUR,
    input  logic                     MemRead,
    input  logic                     MemWrite,
    input  logic                     MemtoReg,
    input  logic                     RegWrite,
    input  logic                     Branch,
    output logic [DATA_WIDTH-1:0]    Address,
    output logic [REG_DIR_WIDTH-1:0] WriteReg_M,
    output logic                     RegWrite_M,
    output logic                     PCSrc,
    output logic [PC_WIDTH-1:0]      BranchTarget,
    output logic [DATA_WIDTH-1:0]    WBData,
    output logic [REG_DIR_WIDTH-1:0] WriteReg_W,
    output logic                     RegWrite_W,
    output logic                     AddrFault
);

    // EX/MEM register
    logic [DATA_WIDTH-1:0]    alu_m_q,   alu_m_d;
    logic [DATA_WIDTH-1:0]    data2_m_q, data2_m_d;
    logic                     zero_m_q,  zero_m_d;
    logic [REG_DIR_WIDTH-1:0] wreg_m_q,  wreg_m_d;
    logic [PC_WIDTH-1:0]      alur_m_q,  alur_m_d;
    ex_mem_ctrl_t             ctrl_m_q,  ctrl_m_d;
    ex_mem_ctrl_t             ctrl_in_c;

    // MEM/WB register
    logic [DATA_WIDTH-1:0]    alu_w_q,   alu_w_d;
    logic [DATA_WIDTH-1:0]    mdata_w_q, mdata_w_d;
    logic [REG_DIR_WIDTH-1:0] wreg_w_q,  wreg_w_d;
    mem_wb_ctrl_t             ctrl_w_q,  ctrl_w_d;

    logic [MEM_ADDR_WIDTH-1:0] mem_idx_c;
    logic                      mem_we_c;
    logic [DATA_WIDTH-1:0]     mem_rdata_c;
    logic [DATA_WIDTH-1:0]     rd_data_c;
    logic                      addr_fault_c;

    always_comb begin
        ctrl_in_c.mem_read   = MemRead;
        ctrl_in_c.mem_write  = MemWrite;
        ctrl_in_c.mem_to_reg = MemtoReg;
        ctrl_in_c.reg_write  = RegWrite;
        ctrl_in_c.branch     = Branch;
    end

    // A flush still loads data fields but kills every control bit, overriding stall.
    always_comb begin
        alu_m_d   = alu_m_q;
        data2_m_d = data2_m_q;
        zero_m_d  = zero_m_q;
        wreg_m_d  = wreg_m_q;
        alur_m_d  = alur_m_q;
        ctrl_m_d  = ctrl_m_q;
        if (flush || !stall) begin
            alu_m_d   = ALUResult;
            data2_m_d = data2;
            zero_m_d  = Zero;
            wreg_m_d  = WriteReg;
            alur_m_d  = ALUR;
            ctrl_m_d  = flush ? EXM_BUBBLE : ctrl_in_c;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alu_m_q   <= '0;
            data2_m_q <= '0;
            zero_m_q  <= 1'b0;
            wreg_m_q  <= '0;
            alur_m_q  <= '0;
            ctrl_m_q  <= EXM_BUBBLE;
        end else begin
            alu_m_q   <= alu_m_d;
            data2_m_q <= data2_m_d;
            zero_m_q  <= zero_m_d;
            wreg_m_q  <= wreg_m_d;
            alur_m_q  <= alur_m_d;
            ctrl_m_q  <= ctrl_m_d;
        end
    end

`ifdef MEM_ADDR_CHECK_EN
    assign addr_fault_c = ((alu_m_q >> MEM_ADDR_WIDTH) != '0)
                        && (ctrl_m_q.mem_read || ctrl_m_q.mem_write);
`else
    assign addr_fault_c = 1'b0;
`endif

    // Upper address bits are dropped, so the index wraps within the memory.
    assign mem_idx_c = alu_m_q[MEM_ADDR_WIDTH-1:0];
    assign mem_we_c  = ctrl_m_q.mem_write && !stall && !addr_fault_c;
    assign rd_data_c = (ctrl_m_q.mem_read && !addr_fault_c) ? mem_rdata_c : '0;

    data_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (MEM_ADDR_WIDTH)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we_c),
        .addr  (mem_idx_c),
        .wdata (data2_m_q),
        .rdata (mem_rdata_c)
    );

    always_comb begin
        alu_w_d   = alu_w_q;
        mdata_w_d = mdata_w_q;
        wreg_w_d  = wreg_w_q;
        ctrl_w_d  = ctrl_w_q;
        if (!stall || flush) begin
            alu_w_d   = alu_m_q;
            mdata_w_d = rd_data_c;
            wreg_w_d  = wreg_m_q;
            ctrl_w_d  = wb_ctrl(ctrl_m_q);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alu_w_q   <= '0;
            mdata_w_q <= '0;
            wreg_w_q  <= '0;
            ctrl_w_q  <= MWB_BUBBLE;
        end else begin
            alu_w_q   <= alu_w_d;
            mdata_w_q <= mdata_w_d;
            wreg_w_q  <= wreg_w_d;
            ctrl_w_q  <= ctrl_w_d;
        end
    end

    assign Address      = alu_m_q;
    assign WriteReg_M   = wreg_m_q;
    assign RegWrite_M   = ctrl_m_q.reg_write;
    assign PCSrc        = ctrl_m_q.branch && zero_m_q;
    assign BranchTarget = alur_m_q;
    assign WBData       = ctrl_w_q.mem_to_reg ? mdata_w_q : alu_w_q;
    assign WriteReg_W   = wreg_w_q;
    assign RegWrite_W   = ctrl_w_q.reg_write;
    assign AddrFault    = addr_fault_c;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: vector table with a write-back scoreboard, plus
// hand sequences for flush, stall and mid-operation reset.
module tb_mem_stage;

    logic       clk = 1'b0;
    logic       reset, stall, flush;
    logic [7:0] ALUResult, data2;
    logic       Zero;
    logic [2:0] WriteReg;
    logic [5:0] ALUR;
    logic       MemRead, MemWrite, MemtoReg, RegWrite, Branch;
    logic [7:0] Address;
    logic [2:0] WriteReg_M;
    logic       RegWrite_M, PCSrc;
    logic [5:0] BranchTarget;
    logic [7:0] WBData;
    logic [2:0] WriteReg_W;
    logic       RegWrite_W, AddrFault;

    int n_tests = 0;
    int n_fail  = 0;

    mem_stage u_dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .ALUResult(ALUResult), .data2(data2), .Zero(Zero), .WriteReg(WriteReg), .ALUR(ALUR),
        .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
        .Branch(Branch), .Address(Address), .WriteReg_M(WriteReg_M), .RegWrite_M(RegWrite_M),
        .PCSrc(PCSrc), .BranchTarget(BranchTarget), .WBData(WBData), .WriteReg_W(WriteReg_W),
        .RegWrite_W(RegWrite_W), .AddrFault(AddrFault)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] alu;
        logic [7:0] d2;
        logic       zero;
        logic [2:0] wr;
        logic [5:0] alur;
        logic       mr, mw, mtr, rw, br;
        logic       e_pcsrc;
        logic       e_fault;
        logic [7:0] e_wb;
    } vec_t;

    typedef struct {
        logic [7:0] wb;
        logic       rw;
        logic [2:0] wr;
    } wb_exp_t;

    vec_t    vecs[13];
    wb_exp_t sb[$];

    function automatic vec_t mk(input logic [7:0] alu, input logic [7:0] d2, input logic zero,
                                input logic [2:0] wr, input logic [5:0] alur,
                                input logic mr, input logic mw, input logic mtr,
                                input logic rw, input logic br,
                                input logic e_pcsrc, input logic e_fault, input logic [7:0] e_wb);
        vec_t v;
        v.alu = alu; v.d2 = d2; v.zero = zero; v.wr = wr; v.alur = alur;
        v.mr = mr; v.mw = mw; v.mtr = mtr; v.rw = rw; v.br = br;
        v.e_pcsrc = e_pcsrc; v.e_fault = e_fault; v.e_wb = e_wb;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [7:0] alu, input logic [7:0] d2, input logic zero,
                         input logic [2:0] wr, input logic [5:0] alur,
                         input logic mr, input logic mw, input logic mtr,
                         input logic rw, input logic br);
        ALUResult = alu; data2 = d2; Zero = zero; WriteReg = wr; ALUR = alur;
        MemRead = mr; MemWrite = mw; MemtoReg = mtr; RegWrite = rw; Branch = br;
    endtask

    task automatic nop();
        drive(8'h00, 8'h00, 1'b0, 3'd0, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    localparam logic FLT = `ifdef MEM_ADDR_CHECK_EN 1'b1 `else 1'b0 `endif;

    initial begin
        wb_exp_t e;
        reset = 1'b1; stall = 1'b0; flush = 1'b0;
        nop();
        #1;
        chk("rst_addr",   32'(Address),      32'h0);
        chk("rst_pcsrc",  32'(PCSrc),        32'h0);
        chk("rst_wbdata", 32'(WBData),       32'h0);
        chk("rst_rww",    32'(RegWrite_W),   32'h0);
        chk("rst_bt",     32'(BranchTarget), 32'h0);
        @(negedge clk);
        reset = 1'b0;

        //            alu    d2    z   wr    alur  mr mw mtr rw br  pc flt wb
        vecs[0]  = mk(8'h05, 8'hA7, 0, 3'd0, 6'h00, 0, 1, 0, 0, 0,  0, 0,   8'h05);
        vecs[1]  = mk(8'h05, 8'h00, 0, 3'd3, 6'h00, 1, 0, 1, 1, 0,  0, 0,   8'hA7);
        vecs[2]  = mk(8'h00, 8'h00, 1, 3'd0, 6'h2C, 0, 0, 0, 0, 1,  1, 0,   8'h00);
        vecs[3]  = mk(8'h3C, 8'h00, 0, 3'd5, 6'h00, 0, 0, 0, 1, 0,  0, 0,   8'h3C);
        vecs[4]  = mk(8'h09, 8'h00, 0, 3'd0, 6'h15, 0, 0, 0, 0, 1,  0, 0,   8'h09);
        vecs[5]  = mk(8'h25, 8'h5A, 0, 3'd0, 6'h00, 0, 1, 0, 0, 0,  0, FLT, 8'h25);
        vecs[6]  = mk(8'h05, 8'h00, 0, 3'd2, 6'h00, 1, 0, 1, 1, 0,  0, 0,   FLT ? 8'hA7 : 8'h5A);
        vecs[7]  = mk(8'h25, 8'h00, 0, 3'd6, 6'h00, 1, 0, 1, 1, 0,  0, FLT, FLT ? 8'h00 : 8'h5A);
        vecs[8]  = mk(8'h1F, 8'hC3, 0, 3'd0, 6'h00, 0, 1, 0, 0, 0,  0, 0,   8'h1F);
        vecs[9]  = mk(8'h1F, 8'h00, 0, 3'd7, 6'h00, 1, 0, 1, 1, 0,  0, 0,   8'hC3);
        vecs[10] = mk(8'h00, 8'h0E, 0, 3'd0, 6'h00, 0, 1, 0, 0, 0,  0, 0,   8'h00);
        vecs[11] = mk(8'h00, 8'h00, 0, 3'd1, 6'h00, 1, 0, 1, 1, 0,  0, 0,   8'h0E);
        vecs[12] = mk(8'h00, 8'h00, 0, 3'd0, 6'h00, 0, 0, 0, 0, 0,  0, 0,   8'h00);

        e.wb = 8'h00; e.rw = 1'b0; e.wr = 3'd0;
        sb.push_back(e);
        for (int i = 0; i < 13; i++) begin
            drive(vecs[i].alu, vecs[i].d2, vecs[i].zero, vecs[i].wr, vecs[i].alur,
                  vecs[i].mr, vecs[i].mw, vecs[i].mtr, vecs[i].rw, vecs[i].br);
            step();
            chk($sformatf("v%0d_addr", i),  32'(Address),      32'(vecs[i].alu));
            chk($sformatf("v%0d_pcsrc", i), 32'(PCSrc),        32'(vecs[i].e_pcsrc));
            chk($sformatf("v%0d_bt", i),    32'(BranchTarget), 32'(vecs[i].alur));
            chk($sformatf("v%0d_rwm", i),   32'(RegWrite_M),   32'(vecs[i].rw));
            chk($sformatf("v%0d_wrm", i),   32'(WriteReg_M),   32'(vecs[i].wr));
            chk($sformatf("v%0d_fault", i), 32'(AddrFault),    32'(vecs[i].e_fault));
            if (sb.size() == 0) begin
                chk($sformatf("v%0d_sb_empty", i), 32'(1), 32'(0));
            end else begin
                e = sb.pop_front();
                chk($sformatf("v%0d_wb", i),  32'(WBData),     32'(e.wb));
                chk($sformatf("v%0d_rww", i), 32'(RegWrite_W), 32'(e.rw));
                chk($sformatf("v%0d_wrw", i), 32'(WriteReg_W), 32'(e.wr));
            end
            e.wb = vecs[i].e_wb; e.rw = vecs[i].rw; e.wr = vecs[i].wr;
            sb.push_back(e);
        end

        // Flushed store must not write; flushed RegWrite never reaches WB.
        drive(8'h03, 8'h11, 0, 3'd0, 6'h00, 0, 1, 0, 0, 0);
        step();
        drive(8'h03, 8'h55, 0, 3'd0, 6'h00, 0, 1, 0, 0, 0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_addr", 32'(Address),    32'h03);
        chk("flush_rwm",  32'(RegWrite_M), 32'h0);
        drive(8'h03, 8'h00, 0, 3'd1, 6'h00, 1, 0, 1, 1, 0);
        step();
        nop();
        step();
        chk("flush_mem3", 32'(WBData),     32'h11);
        chk("flush_rww1", 32'(RegWrite_W), 32'h1);
        drive(8'h44, 8'h00, 0, 3'd2, 6'h00, 0, 0, 0, 1, 0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        nop();
        chk("flush_r_rwm", 32'(RegWrite_M), 32'h0);
        step();
        chk("flush_r_rww", 32'(RegWrite_W), 32'h0);
        drive(8'h00, 8'h00, 1, 3'd4, 6'h3F, 0, 0, 0, 1, 1);
        flush = 1'b1; stall = 1'b1;
        step();
        flush = 1'b0; stall = 1'b0;
        nop();
        chk("fl_st_pcsrc", 32'(PCSrc),      32'h0);
        chk("fl_st_rwm",   32'(RegWrite_M), 32'h0);
        chk("fl_st_bt",    32'(BranchTarget), 32'h3F);

        // Stall holds both registers and resumes without loss or duplication.
        drive(8'h12, 8'h00, 0, 3'd2, 6'h00, 0, 0, 0, 1, 0);
        step();
        drive(8'h3C, 8'h00, 0, 3'd4, 6'h00, 0, 0, 0, 1, 0);
        step();
        drive(8'h77, 8'h00, 0, 3'd6, 6'h00, 0, 0, 0, 1, 0);
        stall = 1'b1;
        for (int c = 0; c < 2; c++) begin
            step();
            chk($sformatf("stall%0d_addr", c), 32'(Address),    32'h3C);
            chk($sformatf("stall%0d_rwm", c),  32'(RegWrite_M), 32'h1);
            chk($sformatf("stall%0d_wb", c),   32'(WBData),     32'h12);
            chk($sformatf("stall%0d_wrw", c),  32'(WriteReg_W), 32'd2);
            chk($sformatf("stall%0d_rww", c),  32'(RegWrite_W), 32'h1);
        end
        stall = 1'b0;
        step();
        nop();
        chk("resume_addr", 32'(Address),    32'h77);
        chk("resume_wb",   32'(WBData),     32'h3C);
        chk("resume_wrw",  32'(WriteReg_W), 32'd4);
        step();
        chk("resume_wb2",  32'(WBData),     32'h77);
        chk("resume_wrw2", 32'(WriteReg_W), 32'd6);

        // Reset while a store sits in EX/MEM: clears at once and drops the store.
        drive(8'h07, 8'h44, 0, 3'd0, 6'h00, 0, 1, 0, 0, 0);
        step();
        drive(8'h07, 8'h99, 0, 3'd0, 6'h0A, 0, 1, 0, 0, 0);
        step();
        nop();
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("mrst_addr",  32'(Address),      32'h0);
        chk("mrst_bt",    32'(BranchTarget), 32'h0);
        chk("mrst_wb",    32'(WBData),       32'h0);
        chk("mrst_rwm",   32'(RegWrite_M),   32'h0);
        chk("mrst_rww",   32'(RegWrite_W),   32'h0);
        @(negedge clk);
        reset = 1'b0;
        drive(8'h07, 8'h00, 0, 3'd3, 6'h00, 1, 0, 1, 1, 0);
        step();
        nop();
        step();
        chk("mrst_mem7", 32'(WBData),     32'h44);
        chk("mrst_wrw",  32'(WriteReg_W), 32'd3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
